axi_pkt_gen: RTL

AXI_PKT_GEN -- requirements
Module: axi_pkt_gen

---
 rtl/ravenoc_pkg.sv | 50 +++++
 rtl/router_if.sv | 17 +
 rtl/axi_pkt_gen.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ravenoc_pkg.sv
// ============================================================================
// ravenoc_pkg : shared NoC widths, flit type enum and flit/handshake structs
// Rev 1.0
// ============================================================================
`default_nettype none

package ravenoc_pkg;

  localparam int X_WIDTH         = 2;
  localparam int Y_WIDTH         = 2;
  localparam int PKT_WIDTH       = 10;
  localparam int VC_WIDTH        = 2;
  localparam int FLIT_DATA_WIDTH = 32;
  localparam int FLIT_TP_WIDTH   = 2;
  localparam int FLIT_WIDTH      = FLIT_TP_WIDTH + FLIT_DATA_WIDTH;
  localparam int HEAD_PAD_WIDTH  = FLIT_DATA_WIDTH - X_WIDTH - Y_WIDTH - PKT_WIDTH;

  typedef enum logic [FLIT_TP_WIDTH-1:0] {
    HEAD_FLIT = 2'd0,
    BODY_FLIT = 2'd1,
    TAIL_FLIT = 2'd2
  } flit_type_t;

  typedef struct packed {
    flit_type_t                 type_f;
    logic [X_WIDTH-1:0]         x_dest;
    logic [Y_WIDTH-1:0]         y_dest;
    logic [PKT_WIDTH-1:0]       pkt_size;
    logic [HEAD_PAD_WIDTH-1:0]  pad;
  } s_flit_head_data_t;

  typedef struct packed {
    logic                  valid;
    logic [FLIT_WIDTH-1:0] fdata;
    logic [VC_WIDTH-1:0]   vc_id;
  } s_flit_req_t;

  typedef struct packed {
    logic ready;
  } s_flit_resp_t;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    SEND_HEAD    = 2'd1,
    SEND_PAYLOAD = 2'd2
  } pkt_gen_st_t;

endpackage : ravenoc_pkg

`default_nettype wire

// File: rtl/router_if.sv
// ============================================================================
// router_if : flit request/response bundle between a flit source and sink
// Rev 1.0
// ============================================================================
`default_nettype none

interface router_if;
  import ravenoc_pkg::*;

  s_flit_req_t  req;
  s_flit_resp_t resp;

  modport send_flit (output req, input resp);
  modport recv_flit (input req, output resp);
endinterface : router_if

`default_nettype wire

// File: rtl/axi_pkt_gen.sv
// ============================================================================
// axi_pkt_gen : turns a packet request plus a payload beat stream into NoC flits
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_pkt_gen
  import ravenoc_pkg::*;
#(
  parameter int MAX_SZ_PKT = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk_axi,
  input  logic                       arst_axi,
  input  logic                       pkt_valid,
  output logic                       pkt_ready,
  input  logic [X_WIDTH-1:0]         pkt_x_dest,
  input  logic [Y_WIDTH-1:0]         pkt_y_dest,
  input  logic [PKT_WIDTH-1:0]       pkt_len,
  input  logic [VC_WIDTH-1:0]        pkt_vc,
  input  logic                       beat_valid,
  output logic                       beat_ready,
  input  logic [FLIT_DATA_WIDTH-1:0] beat_data,
  router_if.send_flit                flit_req_axi_axi,
  output logic                       pkt_err,
  output logic [CNT_WIDTH-1:0]       pkt_sent_cnt
);

  localparam logic [PKT_WIDTH-1:0] MAX_LEN = PKT_WIDTH'(MAX_SZ_PKT);

  pkt_gen_st_t          state_q, state_d;
  logic [X_WIDTH-1:0]   x_q, x_d;
  logic [Y_WIDTH-1:0]   y_q, y_d;
  logic [PKT_WIDTH-1:0] len_q, len_d;
  logic [VC_WIDTH-1:0]  vc_q, vc_d;
  logic [PKT_WIDTH-1:0] remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  s_flit_req_t          flit_req;
  s_flit_head_data_t    head_flit;
  flit_type_t           payload_type;

  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      len_q       <= '0;
      vc_q        <= '0;
      remaining_q <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      len_q       <= len_d;
      vc_q        <= vc_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    len_d        = len_q;
    vc_d         = vc_q;
    remaining_d  = remaining_q;
    cnt_d        = cnt_q;
    err_d        = 1'b0;
    flit_req     = '0;
    beat_ready   = 1'b0;
    pkt_ready    = (state_q == IDLE);
    head_flit    = '0;
    payload_type = (remaining_q == PKT_WIDTH'(1)) ? TAIL_FLIT : BODY_FLIT;

    case (state_q)
      IDLE: begin
        if (pkt_valid) begin
          // Oversized requests are consumed and flagged, never forwarded
          if (pkt_len > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            x_d     = pkt_x_dest;
            y_d     = pkt_y_dest;
            len_d   = pkt_len;
            vc_d    = pkt_vc;
            state_d = SEND_HEAD;
          end
        end
      end

      SEND_HEAD: begin
        head_flit.type_f   = (len_q == '0) ? TAIL_FLIT : HEAD_FLIT;
        head_flit.x_dest   = x_q;
        head_flit.y_dest   = y_q;
        head_flit.pkt_size = len_q;
        flit_req.valid     = 1'b1;
        flit_req.fdata     = head_flit;
        flit_req.vc_id     = vc_q;
        if (flit_req_axi_axi.resp.ready) begin
          if (len_q == '0) begin
            state_d = IDLE;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
          end else begin
            state_d     = SEND_PAYLOAD;
            remaining_d = len_q;
          end
        end
      end

      SEND_PAYLOAD: begin
        flit_req.valid = beat_valid;
        flit_req.vc_id = vc_q;
        beat_ready     = flit_req_axi_axi.resp.ready;
        if (beat_valid) begin
          flit_req.fdata = {payload_type, beat_data};
        end
        if (beat_valid && flit_req_axi_axi.resp.ready) begin
          remaining_d = remaining_q - PKT_WIDTH'(1);
          if (remaining_q == PKT_WIDTH'(1)) begin
            state_d = IDLE;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign flit_req_axi_axi.req = flit_req;
  assign pkt_err              = err_q;
  assign pkt_sent_cnt         = cnt_q;

endmodule : axi_pkt_gen

`default_nettype wire
